xs_sound_cmd_queue: RTL
=======================

Name: xs_sound_cmd_queue

Overview:
- Controls the main-CPU→sound-CPU command path: the sound latch plus the sound-CPU IRQ flip-flop.
- Replaces the single-entry latch with a small FIFO, so back-to-back main-CPU writes (e.g. 09 then 8A within one frame) are never lost.
- Sequences the sound-CPU IRQ: one IRQ per queued command, with a fixed holdoff between consecutive IRQs.
- Sits between the main-CPU write decode (W3A08n) and the sound CPU's latch-region read (0x1000-0x17FF).

Parameters:
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 entries (8).
- HOLDOFF, 64, clk cycles irq_n stays high after an acknowledge before the next IRQ may assert (≥1).

Ports:
- clk  in  1  master clock; the block's only clock.
- RSTn  in  1  asynchronous active-low reset.
- W3A08n  in  1  main-CPU sound-latch write strobe, active low, level.
- DB_in  in  8  main-CPU data bus, sampled at the W3A08n rising edge.
- lat_rd  in  1  sound CPU reading the latch region (decode low AND E high), active high, level.
- pause_rq  in  1  freezes the holdoff counter and IRQ re-assertion; pushes and pops still complete.
- cmd_out  out  8  command presented to the sound-CPU data mux.
- irq_n  out  1  sound-CPU IRQ, active low.
- level  out  DEPTH_LOG2+1  number of entries held, including the presented head.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (async, RSTn=0): cmd_out=8'h00, irq_n=1, level=0, overflow=0, state=IDLE, FIFO pointers=0, edge registers=1/0. Everything leaves reset on the first clk edge after RSTn rises.
- Push: rising edge of W3A08n, detected with a registered copy at clk.
  - Edge seen in cycle N → DB_in captured in cycle N.
  - If not full: entry written and level increments at N+1.
  - If full: entry dropped, level unchanged, overflow=1 until reset.
- Pop: falling edge of lat_rd, i.e. end of the read bus cycle.
  - cmd_out is held stable for the whole time lat_rd is high.
- States:
  - IDLE: level=0, irq_n=1. A push moves to PRESENT next cycle; cmd_out=new head and irq_n=0 at N+1.
  - PRESENT: irq_n=0, cmd_out=head. A lat_rd rising edge sets irq_n=1 at the next cycle (IRQ clear on read, as the original latch decode does). The lat_rd falling edge pops and moves to HOLD.
  - HOLD: irq_n=1, counter loaded with HOLDOFF-1 and decremented each cycle unless pause_rq=1. At 0: go to PRESENT if level>0 (cmd_out=new head, irq_n=0 next cycle), else IDLE.
- cmd_out never changes except on the IDLE→PRESENT and HOLD→PRESENT transitions. After the last pop it keeps the last command, mimicking the latch.
- Push and pop in the same cycle: both take effect and level is unchanged.
  - At level=1, the pushed entry becomes the next head after HOLD; it is never dropped.
  - At full with a simultaneous pop, the push is accepted (not an overflow).
- lat_rd falling with no preceding rising edge in PRESENT (spurious, e.g. after reset): ignored.
- lat_rd in IDLE or HOLD: no pop and no state change.
- Pointers wrap modulo 2**DEPTH_LOG2. level saturates at 2**DEPTH_LOG2 and never wraps.
- RSTn asserted mid-HOLD or mid-read: immediate return to the reset values; queued commands are discarded.

Decomposition:
- Package xs_sound_pkg:
  - typedef enum logic [1:0] {IDLE, PRESENT, HOLD} sndq_state_t;
  - localparam defaults SNDQ_DEPTH_LOG2=3, SNDQ_HOLDOFF=64.
- One sub-module, xs_cmd_fifo: synchronous FIFO with async reset, push/pop/full/empty/level and a registered head output. The FSM, edge detectors, holdoff counter and overflow flag live in xs_sound_cmd_queue.

Test Plan:
- Single command: W3A08n low→high with DB_in=8'h8A → next cycle cmd_out=8'h8A, irq_n=0, level=1. lat_rd pulse → irq_n=1 after the lat_rd rise; level=0 after the fall; HOLD for 64 cycles; then IDLE with irq_n still 1.
- Back-to-back: writes 8'h09 then 8'h8A 10 cycles apart, before any read → first IRQ presents 09. After its read plus 64 holdoff cycles, irq_n=0 with cmd_out=8A. Exactly two IRQ assertions total.
- Overflow: 9 writes (0x01..0x09) with no reads → level=8, overflow=1. Draining yields 01..08 in order; 09 never appears.
- Simultaneous: at level=8, push 0x55 in the same cycle as a lat_rd fall → level stays 8, overflow=0, and 0x55 is read out last.
- Pause: pause_rq=1 during HOLD with level=1 → irq_n stays 1 indefinitely. Deassert → irq_n=0 after the remaining count.
- Reset mid-operation: RSTn=0 in PRESENT with level=3 → at once irq_n=1, cmd_out=00, level=0, overflow=0. After release, a new write behaves as in the single-command case.

Source files
------------

// File: rtl/xs_sound_pkg.sv
// rtl/xs_sound_pkg.sv - shared types and defaults for the sound command queue
// Contents:
//   sndq_state_t     IRQ sequencer state (IDLE, PRESENT, HOLD)
//   SNDQ_DEPTH_LOG2  default log2 of the command FIFO depth
//   SNDQ_HOLDOFF     default clk cycles between an acknowledge and the next IRQ
package xs_sound_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } sndq_state_t;

    localparam int SNDQ_DEPTH_LOG2 = 3;
    localparam int SNDQ_HOLDOFF    = 64;

endpackage

// File: rtl/xs_cmd_fifo.sv
// rtl/xs_cmd_fifo.sv - synchronous command FIFO with a registered head output
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, wdata  write request and data; ignored when full unless a pop lands in the same cycle
//   pop          read request; ignored when empty
//   full, empty  occupancy flags
//   level        entries held (0 .. 2**DEPTH_LOG2), saturating
//   head         registered copy of the oldest entry
module xs_cmd_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [WIDTH-1:0]      head
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_next;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end

            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // The head register tracks mem[rd_ptr]; when the slot it moves to is
            // being written this very cycle, take the write data directly.
            if (do_pop) begin
                if (do_push && (rd_next == wr_ptr)) begin
                    head <= wdata;
                end else begin
                    head <= mem[rd_next];
                end
            end else if (do_push && empty) begin
                head <= wdata;
            end
        end
    end

endmodule

// File: rtl/xs_sound_cmd_queue.sv
// rtl/xs_sound_cmd_queue.sv - main-CPU to sound-CPU command queue with IRQ sequencing
// Ports:
//   clk       master clock
//   RSTn      asynchronous active-low reset
//   W3A08n    main-CPU sound-latch write strobe (active low); a rising edge pushes DB_in
//   DB_in     main-CPU data bus
//   lat_rd    sound CPU reading the latch region; rising edge clears IRQ, falling edge pops
//   pause_rq  freezes the holdoff counter and IRQ re-assertion
//   cmd_out   command presented to the sound-CPU data mux
//   irq_n     sound-CPU IRQ, active low
//   level     entries held, including the presented head
//   overflow  sticky: a write was dropped because the FIFO was full
module xs_sound_cmd_queue
    import xs_sound_pkg::*;
#(
    parameter int DEPTH_LOG2 = SNDQ_DEPTH_LOG2,
    parameter int HOLDOFF    = SNDQ_HOLDOFF
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                W3A08n,
    input  logic [7:0]          DB_in,
    input  logic                lat_rd,
    input  logic                pause_rq,
    output logic [7:0]          cmd_out,
    output logic                irq_n,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF - 1);

    sndq_state_t state;
    logic        w_q;
    logic        lat_q;
    logic        read_seen;
    logic [CNT_W-1:0] cnt;

    logic        push_edge;
    logic        lat_rise;
    logic        lat_fall;
    logic        pop_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;

    assign push_edge = W3A08n && !w_q;
    assign lat_rise  = lat_rd && !lat_q;
    assign lat_fall  = !lat_rd && lat_q;
    // Only a read that started while presenting acknowledges the command; a
    // falling edge left over from before (e.g. after reset) is ignored.
    assign pop_req   = (state == PRESENT) && lat_fall && read_seen;

    xs_cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (RSTn),
        .push  (push_edge),
        .wdata (DB_in),
        .pop   (pop_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            w_q      <= 1'b1;
            lat_q    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            w_q   <= W3A08n;
            lat_q <= lat_rd;
            if (push_edge && fifo_full && !pop_req) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            cmd_out   <= 8'h00;
            irq_n     <= 1'b1;
            cnt       <= '0;
            read_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    irq_n <= 1'b1;
                    // A non-empty FIFO here means a push arrived on the last
                    // HOLD cycle; otherwise a fresh push is the new head.
                    if (!fifo_empty) begin
                        cmd_out <= fifo_head;
                        irq_n   <= 1'b0;
                        state   <= PRESENT;
                    end else if (push_edge) begin
                        cmd_out <= DB_in;
                        irq_n   <= 1'b0;
                        state   <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (pop_req) begin
                        state     <= HOLD;
                        cnt       <= CNT_LOAD;
                        read_seen <= 1'b0;
                        irq_n     <= 1'b1;
                    end else if (lat_rise) begin
                        read_seen <= 1'b1;
                        irq_n     <= 1'b1;
                    end
                end

                HOLD: begin
                    irq_n <= 1'b1;
                    if (!pause_rq) begin
                        if (cnt == '0) begin
                            if (!fifo_empty) begin
                                cmd_out <= fifo_head;
                                irq_n   <= 1'b0;
                                state   <= PRESENT;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    irq_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
